// File: rtl/alu_op_decoder.sv
// Decode/issue stage for the RV32IM ALU: decodes one instruction per cycle into a registered
// {rs1, rs2, func7, func3, rd} bundle behind a 2-entry skid buffer with a registered in_ready.
module alu_op_decoder #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [6:0]      out_func7,
    output logic [2:0]      out_func3,
    output logic [4:0]      out_rd,
    output logic            out_illegal,
    output logic [7:0]      illegal_cnt
);

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcAuipc = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [6:0]      func7;
        logic [2:0]      func3;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_t;

    state_t     state_q;
    entry_t     main_q;
    entry_t     skid_q;
    entry_t     dec;
    logic       out_valid_q;
    logic       in_ready_q;
    logic [7:0] illegal_cnt_q;
    logic       legal;
    logic       accept;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_u  = {in_instr[31:12], 12'b0};

    assign rf_raddr1 = in_instr[19:15];
    assign rf_raddr2 = in_instr[24:20];

    assign accept = in_valid & in_ready_q & ~flush;

    always_comb begin
        dec    = '0;
        dec.rd = in_instr[11:7];
        legal  = 1'b0;
        // Opcode includes instr[1:0], so non-32-bit encodings fall into the default arm.
        case (opcode)
            OpcOp: begin
                dec.rs1   = rf_rdata1;
                dec.rs2   = rf_rdata2;
                dec.func3 = f3;
                dec.func7 = f7;
                legal     = (f7 == 7'h00) || (f7 == 7'h01) ||
                            ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            end
            OpcOpImm: begin
                dec.rs1   = rf_rdata1;
                dec.rs2   = imm_i;
                dec.func3 = f3;
                if ((f3 == 3'd1) || (f3 == 3'd5)) begin
                    dec.func7 = f7;
                    legal     = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd5));
                end else begin
                    // Immediate bits 30/25 must not leak into func7 as SUB or M-ops.
                    dec.func7 = 7'h00;
                    legal     = 1'b1;
                end
            end
            OpcLui: begin
                dec.rs2 = imm_u;
                legal   = 1'b1;
            end
            OpcAuipc: begin
                dec.rs1 = in_pc;
                dec.rs2 = imm_u;
                legal   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.rd      = in_instr[11:7];
            dec.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StEmpty;
            main_q        <= '0;
            skid_q        <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            illegal_cnt_q <= '0;
        end else begin
            if (accept && dec.illegal && (illegal_cnt_q != 8'hff)) begin
                illegal_cnt_q <= illegal_cnt_q + 8'd1;
            end
            if (flush) begin
                state_q     <= StEmpty;
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b1;
            end else begin
                case (state_q)
                    StEmpty: begin
                        if (accept) begin
                            main_q      <= dec;
                            out_valid_q <= 1'b1;
                            state_q     <= StOne;
                        end
                    end
                    StOne: begin
                        if (accept) begin
                            if (out_ready) begin
                                main_q <= dec;
                            end else begin
                                skid_q     <= dec;
                                in_ready_q <= 1'b0;
                                state_q    <= StFull;
                            end
                        end else if (out_ready) begin
                            out_valid_q <= 1'b0;
                            state_q     <= StEmpty;
                        end
                    end
                    StFull: begin
                        if (out_ready) begin
                            main_q     <= skid_q;
                            in_ready_q <= 1'b1;
                            state_q    <= StOne;
                        end
                    end
                    default: begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StEmpty;
                    end
                endcase
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_func7   = main_q.func7;
    assign out_func3   = main_q.func3;
    assign out_rd      = main_q.rd;
    assign out_illegal = main_q.illegal;
    assign illegal_cnt = illegal_cnt_q;

endmodule
